// File: rtl/io_debounce.sv
// io_debounce: per-bit synchroniser and tick-based debouncer feeding io_bamse PortA.
// Define IO_DEBOUNCE_EDGE_EN to add the registered rise_o/fall_o edge pulses.
module io_debounce #(
  parameter int              WIDTH       = 3,
  parameter int              SYNC_STAGES = 2,
  parameter int              PRESCALE    = 1,
  parameter int              DB_COUNT    = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in_i,
  output logic [WIDTH-1:0] pin_out_o,
  output logic             changed_o
`ifdef IO_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(DB_COUNT + 1);
  // sync_q[0] is the first stage; the last stage feeds the debouncer
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [PW-1:0]                     pre_q, pre_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  pin_q, pin_d, s;
  logic                              tick, changed_q;
  assign s     = sync_q[SYNC_STAGES-1];
  assign tick  = pre_q == PW'(PRESCALE - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  always_comb begin
    cnt_d = cnt_q;
    pin_d = pin_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (s[i] == pin_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == CW'(DB_COUNT - 1)) begin
          pin_d[i] = s[i];
          cnt_d[i] = '0;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{RST_VAL}};
      pre_q     <= '0;
      cnt_q     <= '0;
      pin_q     <= RST_VAL;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_in_i};
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      pin_q     <= pin_d;
      changed_q <= |(pin_d ^ pin_q);
    end
  end
  assign pin_out_o = pin_q;
  assign changed_o = changed_q;
`ifdef IO_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= pin_d & ~pin_q;
      fall_q <= ~pin_d & pin_q;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif
endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: directed vector table plus hand sequences for reset, glitch and prescaled latency.
module tb_io_debounce;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pin, pin2;
  logic [2:0] po, po2;
  logic       ch, ch2;
`ifdef IO_DEBOUNCE_EDGE_EN
  logic [2:0] ri, fa, ri2, fa2;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_debounce #(.WIDTH(3), .SYNC_STAGES(2), .PRESCALE(1), .DB_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pin_in_i(pin), .pin_out_o(po), .changed_o(ch)
`ifdef IO_DEBOUNCE_EDGE_EN
    , .rise_o(ri), .fall_o(fa)
`endif
  );

  io_debounce #(.WIDTH(3), .SYNC_STAGES(2), .PRESCALE(4), .DB_COUNT(4)) dut_ps (
    .clk(clk), .rst_n(rst_n), .pin_in_i(pin2), .pin_out_o(po2), .changed_o(ch2)
`ifdef IO_DEBOUNCE_EDGE_EN
    , .rise_o(ri2), .fall_o(fa2)
`endif
  );

  typedef struct {
    logic [2:0] pin;
    logic [2:0] po;
    logic       ch;
    logic [2:0] ri;
    logic [2:0] fa;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] p, input logic [2:0] o, input logic c,
                     input logic [2:0] r, input logic [2:0] f, input int n);
    vec_t v;
    v.pin = p; v.po = o; v.ch = c; v.ri = r; v.fa = f;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    // reset asserted with all pins high: outputs cleared before any clock
    rst_n = 1'b0; pin = 3'b111; pin2 = 3'b000;
    #1;
    chk("rst_po", 32'(po), 0);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_po_ps", 32'(po2), 0);
    repeat (3) step;
    chk("rst_hold_po", 32'(po), 0);
    pin = 3'b000; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("rel_ch", 32'(ch), 0);
      chk("rel_po", 32'(po), 0);
    end

    // single rise: 6 edges latency
    add(3'b001, 3'b000, 0, 3'b000, 3'b000, 5);
    add(3'b001, 3'b001, 1, 3'b001, 3'b000, 1);
    add(3'b001, 3'b001, 0, 3'b000, 3'b000, 2);
    // 3-cycle glitch on bit1 rejected
    add(3'b011, 3'b001, 0, 3'b000, 3'b000, 3);
    add(3'b001, 3'b001, 0, 3'b000, 3'b000, 5);
    // 4-cycle pulse on bit1 accepted, then its low level accepted too
    add(3'b011, 3'b001, 0, 3'b000, 3'b000, 4);
    add(3'b001, 3'b001, 0, 3'b000, 3'b000, 1);
    add(3'b001, 3'b011, 1, 3'b010, 3'b000, 1);
    add(3'b001, 3'b011, 0, 3'b000, 3'b000, 3);
    add(3'b001, 3'b001, 1, 3'b000, 3'b010, 1);
    add(3'b001, 3'b001, 0, 3'b000, 3'b000, 1);
    // simultaneous bit0 fall and bit2 rise
    add(3'b100, 3'b001, 0, 3'b000, 3'b000, 5);
    add(3'b100, 3'b100, 1, 3'b100, 3'b001, 1);
    add(3'b100, 3'b100, 0, 3'b000, 3'b000, 2);

    foreach (tbl[k]) begin
      pin = tbl[k].pin;
      step;
      chk($sformatf("v%0d_po", k), 32'(po), 32'(tbl[k].po));
      chk($sformatf("v%0d_ch", k), 32'(ch), 32'(tbl[k].ch));
`ifdef IO_DEBOUNCE_EDGE_EN
      chk($sformatf("v%0d_rise", k), 32'(ri), 32'(tbl[k].ri));
      chk($sformatf("v%0d_fall", k), 32'(fa), 32'(tbl[k].fa));
`endif
    end

    // reset in the middle of a pending change
    pin = 3'b010;
    repeat (4) step;
    chk("pre_rst_po", 32'(po), 32'(3'b100));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_po", 32'(po), 0);
    chk("mid_rst_ch", 32'(ch), 0);
    pin = 3'b000;
    repeat (2) step;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("post_rst_po", 32'(po), 0);
      chk("post_rst_ch", 32'(ch), 0);
    end

    // PRESCALE=4 latency window
    pin2 = 3'b001;
    e = 0;
    while (po2 !== 3'b001 && e < 40) begin
      step;
      e++;
    end
    if (e < 15 || e > 18) $display("FAIL ps4_latency: got %0d edges expected 15..18", e);
    n_vec++;
    if (e < 15 || e > 18) n_err++;
    chk("ps4_po", 32'(po2), 32'(3'b001));
    // 10-cycle pulse spans at most 3 ticks and is rejected
    step;
    pin2 = 3'b011;
    repeat (10) step;
    pin2 = 3'b001;
    for (int i = 0; i < 30; i++) begin
      step;
      chk("ps4_glitch_po", 32'(po2), 32'(3'b001));
      chk("ps4_glitch_ch", 32'(ch2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
